controlador_botones: RTL
========================

# controlador_botones

Memory-mapped event controller for the board's switches and push buttons. It sits between the already-debounced button levels / raw switches and the CPU data bus. It synchronises the inputs, detects button presses as rising edges and latches them as sticky pending events. It applies a CPU-programmed mask, drives a level interrupt request and keeps a press counter, all readable and clearable by software.

## Interface
Parameters:
- N_SW, 16, number of switch inputs.
- N_BTN, 4, number of debounced button inputs.
- CNT_W, 16, width of the press counter.

Ports:
- clck_i  input  1  system clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high; clears all state immediately.
- switches_i  input  N_SW  raw switch levels, asynchronous to clck_i.
- botones_i  input  N_BTN  debounced button levels, one-pulse-free (steady levels).
- addr_i  input  2  register select.
- we_i  input  1  write strobe, one cycle.
- re_i  input  1  read strobe, one cycle.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, registered.
- irq_o  output  1  interrupt request, registered level.

## Operation
- Input path: switches_i and botones_i pass through a 2-flop synchroniser, then one history flop per bit for edge detection.
- Button event i: synced level 1 and history 0 (rising edge) sets pend[i]; falling edges are ignored.
- Every button rising edge (any i) increments cnt by the number of simultaneous edges; cnt wraps modulo 2^CNT_W.
- Register map (addr_i):
  - 0 ESTADO (RO): {12'b0, btn_sync[3:0], sw_sync[15:0]}.
  - 1 PEND (R/W1C): pend in bits [4:0], upper bits read 0; writing 1 clears the bit, writing 0 has no effect.
  - 2 MASK (RW): bits [4:0], reset 0; upper write bits ignored.
  - 3 CNT (RO/clear): bits [CNT_W-1:0]; any write clears it to 0.
- Writes to RO fields are ignored.
- irq_o = |(pend & mask), registered.
- Same-cycle set and W1C of the same pend bit: set wins, bit stays 1.
- Same-cycle increment and CNT write: counter loads the increment value (0 + edges), so no press is lost.
- we_i and re_i in the same cycle: the read returns pre-write contents.
- Reset values: rdata_o = 0, irq_o = 0, pend = 0, mask = 0, cnt = 0, all sync/history flops = 0.
  - A button held high through reset release therefore produces one event after synchronisation (intended).

## Timing
- Input change sampled at edge k: visible in sync output after edge k+1; pend/cnt updated at edge k+2; irq_o asserted at edge k+3.
- Read: re_i high at edge j, rdata_o valid after edge j; held until the next read.
- Write: takes effect at the edge it is sampled. irq_o reflects a MASK write or PEND clear one edge later.
- No backpressure; every strobe completes in one cycle.
- rst_i asserted mid-operation clears all outputs asynchronously, without waiting for a clock edge.

## Configuration
- SWITCH_CHANGE_EVENT_EN defined: pend[4] is set whenever any synced switch differs from its history (either direction), maskable by mask[4]. Switch changes do not affect cnt.
- Undefined: pend[4] and mask[4] are constant 0; the switch path has no history flops.

## Structure
- Package controlador_botones_pkg holds:
  - the address constants ADDR_ESTADO, ADDR_PEND, ADDR_MASK, ADDR_CNT;
  - the event index constants EV_BTN0..EV_BTN3, EV_SW;
  - N_EV = 5.
- One sub-module, sincronizador: parameterised-width 2-flop synchroniser with asynchronous active-high reset, instantiated once for switches and once for buttons.

## Test plan
- Reset, then read all four addresses → ESTADO = 0x0, PEND = 0, MASK = 0, CNT = 0; irq_o = 0.
- switches_i = 0xA5A5, botones_i = 0x3, wait 3 cycles, read ESTADO → 0x0003A5A5; PEND bits 0–1 = 1; CNT = 2.
- MASK = 0x01, pulse btn0 → irq_o high exactly 3 edges after the sample edge; write PEND = 0x01 → irq_o low one edge later.
- Hold W1C of pend[2] in the same cycle as a btn2 rising edge reaches pend → pend[2] reads 1.
- Preload CNT to 0xFFFF via 65535 presses (or force), press once → CNT = 0x0000. Write CNT in the same cycle as an edge → CNT = 1.
- With SWITCH_CHANGE_EVENT_EN and MASK = 0x10, toggle switch 7 → pend[4] = 1 and irq_o = 1, CNT unchanged. Without the macro → pend[4] = 0 and irq_o = 0.

Source files
------------

// File: rtl/controlador_botones_pkg.sv
// Shared constants for controlador_botones: register map addresses,
// event bit positions and an edge-count helper.
package controlador_botones_pkg;

  // Register map
  localparam logic [1:0] ADDR_ESTADO = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  // Event bit positions inside PEND / MASK
  localparam int EV_BTN0 = 0;
  localparam int EV_BTN1 = 1;
  localparam int EV_BTN2 = 2;
  localparam int EV_BTN3 = 3;
  localparam int EV_SW   = 4;
  localparam int N_EV    = 5;

  // Number of simultaneous button rising edges in one cycle
  function automatic logic [2:0] count_edges(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/controlador_botones_sincronizador.sv
// Two-flop synchroniser, parameterised width, asynchronous active-high reset.
module sincronizador #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // Two-stage shift: first stage may go metastable, second stage is the clean output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/controlador_botones.sv
// Memory-mapped switch/button event controller.
// Synchronises inputs, latches button rising edges as sticky pending events,
// applies a CPU mask to drive a level interrupt and counts presses.
// Optional feature: define SWITCH_CHANGE_EVENT_EN to raise pend[4] on any
// switch change (maskable by mask[4]); otherwise pend[4]/mask[4] stay 0.
// The register map has room for four buttons, so N_BTN must not exceed 4.
module controlador_botones
  import controlador_botones_pkg::*;
#(
  parameter int N_SW  = 16,
  parameter int N_BTN = 4,
  parameter int CNT_W = 16
) (
  input  logic             clck_i,
  input  logic             rst_i,
  input  logic [N_SW-1:0]  switches_i,
  input  logic [N_BTN-1:0] botones_i,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o
);

`ifdef SWITCH_CHANGE_EVENT_EN
  localparam logic [N_EV-1:0] MASK_WRITABLE = 5'h1F;
`else
  localparam logic [N_EV-1:0] MASK_WRITABLE = 5'h0F;
`endif

  logic [N_SW-1:0]  sw_sync;
  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] btn_hist;
  logic [3:0]       btn_rise;
  logic             sw_change;

  logic [N_EV-1:0]  pend;
  logic [N_EV-1:0]  mask;
  logic [CNT_W-1:0] cnt;

  logic [N_EV-1:0]  set_ev;
  logic [N_EV-1:0]  clr_ev;
  logic [N_EV-1:0]  pend_next;
  logic [N_EV-1:0]  mask_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      rd_val;

  // Upper write-data bits have no destination in this register map
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:N_EV];

  sincronizador #(.W(N_SW)) u_sync_sw (
    .clk  (clck_i),
    .rst  (rst_i),
    .din  (switches_i),
    .dout (sw_sync)
  );

  sincronizador #(.W(N_BTN)) u_sync_btn (
    .clk  (clck_i),
    .rst  (rst_i),
    .din  (botones_i),
    .dout (btn_sync)
  );

  assign btn_rise = 4'(btn_sync & ~btn_hist);

`ifdef SWITCH_CHANGE_EVENT_EN
  logic [N_SW-1:0] sw_hist;

  // Switch history for change detection in either direction
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      sw_hist <= '0;
    end else begin
      sw_hist <= sw_sync;
    end
  end

  assign sw_change = |(sw_sync ^ sw_hist);
`else
  assign sw_change = 1'b0;
`endif

  // Next-state for events, mask, counter and the read mux (read sees pre-write values)
  always_comb begin
    set_ev                  = '0;
    set_ev[EV_BTN3:EV_BTN0] = btn_rise;
    set_ev[EV_SW]           = sw_change;

    clr_ev = (we_i && (addr_i == ADDR_PEND)) ? wdata_i[N_EV-1:0] : 5'b00000;
    // A new event in the same cycle as its W1C wins
    pend_next = (pend & ~clr_ev) | set_ev;

    mask_next = (we_i && (addr_i == ADDR_MASK)) ? (wdata_i[N_EV-1:0] & MASK_WRITABLE) : mask;

    cnt_inc = CNT_W'(count_edges(btn_rise));
    // A clear coinciding with presses loads the press count so none is lost
    cnt_next = (we_i && (addr_i == ADDR_CNT)) ? cnt_inc : (cnt + cnt_inc);

    case (addr_i)
      ADDR_ESTADO: rd_val = {{(32-N_SW-N_BTN){1'b0}}, btn_sync, sw_sync};
      ADDR_PEND:   rd_val = {{(32-N_EV){1'b0}}, pend};
      ADDR_MASK:   rd_val = {{(32-N_EV){1'b0}}, mask};
      ADDR_CNT:    rd_val = 32'(cnt);
      default:     rd_val = 32'h0000_0000;
    endcase
  end

  // Architectural state and registered outputs
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      btn_hist <= '0;
      pend     <= '0;
      mask     <= '0;
      cnt      <= '0;
      irq_o    <= 1'b0;
      rdata_o  <= 32'h0000_0000;
    end else begin
      btn_hist <= btn_sync;
      pend     <= pend_next;
      mask     <= mask_next;
      cnt      <= cnt_next;
      irq_o    <= |(pend & mask);
      if (re_i) begin
        rdata_o <= rd_val;
      end else begin
        rdata_o <= rdata_o;
      end
    end
  end

endmodule
